// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the per-tile interrupt dispatcher.
package irq_pkg;
    localparam int IRQ_NSRC = 16;
    localparam int IRQ_W    = 4;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} irq_st_t;
endpackage

// File: rtl/irq_dispatch_prio_enc.sv
// 16->4 priority encoder: lowest set index wins, plus an any-request flag.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [IRQ_NSRC-1:0] req,
    output logic [IRQ_W-1:0]    idx,
    output logic                any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan downwards so the lowest set index is the last to be written.
        for (int unsigned i = IRQ_NSRC; i > 0; i--) begin
            if (req[IRQ_W'(i - 1)]) begin
                idx = IRQ_W'(i - 1);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: latches edge/level sources, picks by fixed priority,
// strobes irqload with a stable irqnum and waits for the core's acknowledge.
module irq_dispatch
    import irq_pkg::*;
#(
    parameter int NSRC    = 16,
    parameter int HOLDOFF = 8,
    parameter int ACK_TO  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic [NSRC-1:0] irq_edge_cfg,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            irq_ack,
    output logic            irqload,
    output logic [IRQ_W-1:0] irqnum,
    output logic [NSRC-1:0] irq_pending,
    output logic            irq_busy,
    output logic            irq_timeout
);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TO - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 2);

    logic [1:0]      rst_sync;
    logic            rst_ni;
    irq_st_t         state, state_d;
    logic [IRQ_W-1:0] num_q, num_d;
    logic [NSRC-1:0] pend, pend_d, prev, rise, eligible;
    logic            armed, replay, replay_d, to_q, to_d;
    logic [7:0]      wait_cnt, wait_d, hold_cnt, hold_d;
    logic [IRQ_W-1:0] win_idx;
    logic            win_any, ack_ok, leave_wait, inflight_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ni = rst_sync[1];

    // armed stays low for the first cycle out of reset so prev can capture
    // lines that were already high, avoiding a false edge.
    assign rise     = armed ? (irq_src & ~prev & irq_edge_cfg) : '0;
    assign eligible = pend & irq_mask;
    assign inflight_rise = rise[num_q];
    assign ack_ok     = (state == WAIT) && irq_ack;
    assign leave_wait = (state == WAIT) && (irq_ack || wait_cnt == ACK_LAST);

    irq_prio_enc u_enc (
        .req (eligible),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        pend_d = ((pend | rise) & irq_edge_cfg) | (irq_src & ~irq_edge_cfg);
        if (ack_ok && irq_edge_cfg[num_q] && !replay && !inflight_rise)
            pend_d[num_q] = 1'b0;
    end

    always_comb begin
        replay_d = 1'b0;
        if ((state == LOAD || state == WAIT) && !leave_wait)
            replay_d = replay | inflight_rise;
    end

    always_comb begin
        state_d = state;
        num_d   = num_q;
        wait_d  = wait_cnt;
        hold_d  = hold_cnt;
        to_d    = 1'b0;
        case (state)
            IDLE: if (win_any) begin
                state_d = LOAD;
                num_d   = win_idx;
            end
            LOAD: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: if (leave_wait) begin
                to_d    = !irq_ack;
                hold_d  = '0;
                // HOLD plus the following IDLE cycle make up the HOLDOFF gap.
                state_d = (HOLDOFF > 1) ? HOLD : IDLE;
            end else begin
                wait_d = wait_cnt + 8'd1;
            end
            HOLD: if (hold_cnt == HOLD_LAST) state_d = IDLE;
                  else hold_d = hold_cnt + 8'd1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            num_q    <= '0;
            pend     <= '0;
            prev     <= '0;
            armed    <= 1'b0;
            replay   <= 1'b0;
            to_q     <= 1'b0;
            wait_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            num_q    <= num_d;
            pend     <= pend_d;
            prev     <= irq_src;
            armed    <= 1'b1;
            replay   <= replay_d;
            to_q     <= to_d;
            wait_cnt <= wait_d;
            hold_cnt <= hold_d;
        end
    end

    assign irqload     = (state == LOAD);
    assign irqnum      = num_q;
    assign irq_pending = pend;
    assign irq_busy    = (state != IDLE);
    assign irq_timeout = to_q;
endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch: expected irqnum per irqload queued by stimulus,
// popped and compared by an independent monitor.
module tb_irq_dispatch;
    localparam int HO  = 4;
    localparam int ATO = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] irq_src, irq_edge_cfg, irq_mask;
    logic        irq_ack;
    logic        irqload, irq_busy, irq_timeout;
    logic [3:0]  irqnum;
    logic [15:0] irq_pending;

    irq_dispatch #(.NSRC(16), .HOLDOFF(HO), .ACK_TO(ATO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .irq_edge_cfg (irq_edge_cfg),
        .irq_mask     (irq_mask),
        .irq_ack      (irq_ack),
        .irqload      (irqload),
        .irqnum       (irqnum),
        .irq_pending  (irq_pending),
        .irq_busy     (irq_busy),
        .irq_timeout  (irq_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_to  = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    logic prev_load = 1'b0;
    logic prev_to   = 1'b0;
    always @(negedge clk) begin
        if (prev_load) chk("irqload_width", int'(irqload), 0);
        if (prev_to)   chk("timeout_width", int'(irq_timeout), 0);
        if (irqload) begin
            if (exp_q.size() == 0) chk("spurious_irqload", int'(irqload), 0);
            else                   chk("irqnum", int'(irqnum), int'(exp_q.pop_front()));
        end
        if (irq_timeout) n_to++;
        prev_load = irqload;
        prev_to   = irq_timeout;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_load(output int t);
        int n = 0;
        @(negedge clk);
        while (!irqload && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("load_seen", int'(irqload), 1);
        t = cyc;
    endtask

    task automatic ack_after(input int d);
        tick(d);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, tp, tn;
        rst_n = 1'b0; irq_src = '0; irq_edge_cfg = '1; irq_mask = '1; irq_ack = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_irqload", int'(irqload), 0);
        chk("rst_irqnum", int'(irqnum), 0);
        chk("rst_pending", int'(irq_pending), 0);
        chk("rst_busy", int'(irq_busy), 0);
        chk("rst_timeout", int'(irq_timeout), 0);
        rst_n = 1'b1;
        tick(4);

        // 1: single edge on source 5, ack in third WAIT cycle
        irq_src[5] = 1'b1; tn = cyc; exp_q.push_back(4'd5);
        wait_load(t0);
        chk("t1_latency", t0 - tn, 2);
        @(negedge clk);
        chk("t1_pend_wait", int'(irq_pending[5]), 1);
        chk("t1_busy_wait", int'(irq_busy), 1);
        ack_after(2);
        @(negedge clk);
        chk("t1_pend_clear", int'(irq_pending[5]), 0);
        repeat (2) @(negedge clk);
        chk("t1_busy_hold_end", int'(irq_busy), 1);
        @(negedge clk);
        chk("t1_busy_low", int'(irq_busy), 0);
        tick(1); irq_src[5] = 1'b0;

        // 2: simultaneous edges, priority and back-to-back spacing
        irq_src[2] = 1'b1; irq_src[9] = 1'b1;
        exp_q.push_back(4'd2); exp_q.push_back(4'd9);
        wait_load(t1);
        ack_after(1);
        wait_load(t2);
        chk("t2_spacing", t2 - t1, HO + 2);
        ack_after(1);
        irq_src[2] = 1'b0; irq_src[9] = 1'b0;
        @(negedge clk);
        chk("t2_pend_clear", int'(irq_pending), 0);

        // 3: level source 3 redelivered while high, stops once dropped
        tick(HO);
        irq_edge_cfg[3] = 1'b0; irq_src[3] = 1'b1;
        tp = 0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4'd3);
            wait_load(t0);
            if (k == 0) chk("t3_level_pend", int'(irq_pending[3]), 1);
            else        chk("t3_period", t0 - tp, 2 + HO + 1);
            tp = t0;
            ack_after(2);
            if (k == 2) irq_src[3] = 1'b0;
        end
        tick(20);
        chk("t3_pend_drop", int'(irq_pending[3]), 0);
        chk("t3_idle", int'(irq_busy), 0);
        irq_edge_cfg[3] = 1'b1;

        // 4: no ack -> timeout, pend kept, redelivered
        irq_src[6] = 1'b1;
        exp_q.push_back(4'd6); exp_q.push_back(4'd6);
        wait_load(t1);
        begin
            int n = 0;
            @(negedge clk);
            while (!irq_timeout && n < ATO + 10) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t4_timeout_seen", int'(irq_timeout), 1);
        chk("t4_timeout_time", cyc - t1, ATO + 1);
        chk("t4_pend_kept", int'(irq_pending[6]), 1);
        wait_load(t2);
        chk("t4_redeliver_gap", t2 - t1, ATO + HO + 1);
        ack_after(1);
        irq_src[6] = 1'b0;
        @(negedge clk);
        chk("t4_pend_clear", int'(irq_pending[6]), 0);

        // 5: second edge on in-flight source 7 during WAIT -> replay
        tick(HO);
        irq_src[7] = 1'b1;
        exp_q.push_back(4'd7); exp_q.push_back(4'd7);
        wait_load(t0);
        tick(1); irq_src[7] = 1'b0;
        tick(1); irq_src[7] = 1'b1;
        ack_after(1);
        @(negedge clk);
        chk("t5_replay_pend", int'(irq_pending[7]), 1);
        wait_load(t0);
        ack_after(1);
        irq_src[7] = 1'b0;
        @(negedge clk);
        chk("t5_pend_clear", int'(irq_pending[7]), 0);

        // 5b: edge on the same cycle as the ack counts as replay
        tick(HO);
        irq_src[8] = 1'b1;
        exp_q.push_back(4'd8); exp_q.push_back(4'd8);
        wait_load(t0);
        tick(1); irq_src[8] = 1'b0;
        tick(1); irq_src[8] = 1'b1; irq_ack = 1'b1;
        tick(1); irq_ack = 1'b0;
        @(negedge clk);
        chk("t5b_ack_edge_pend", int'(irq_pending[8]), 1);
        wait_load(t0);
        ack_after(1);
        irq_src[8] = 1'b0;
        @(negedge clk);
        chk("t5b_pend_clear", int'(irq_pending[8]), 0);

        // 6: reset mid-WAIT with masked source 4 pending
        tick(HO);
        irq_mask[4] = 1'b0; irq_src[4] = 1'b1; irq_src[1] = 1'b1;
        exp_q.push_back(4'd1);
        wait_load(t0);
        chk("t6_masked_pend", int'(irq_pending[4]), 1);
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_irqload", int'(irqload), 0);
        chk("t6_rst_irqnum", int'(irqnum), 0);
        chk("t6_rst_pending", int'(irq_pending), 0);
        chk("t6_rst_busy", int'(irq_busy), 0);
        chk("t6_rst_timeout", int'(irq_timeout), 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        irq_mask[4] = 1'b1;
        tick(10);
        chk("t6_no_false_edge", int'(irq_pending), 0);
        chk("t6_idle_after_rst", int'(irq_busy), 0);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        @(negedge clk);
        chk("t6_idle_ack_ignored", int'(irq_busy), 0);
        tick(1); irq_src[4] = 1'b0;
        tick(1); irq_src[4] = 1'b1;
        exp_q.push_back(4'd4);
        wait_load(t0);
        irq_ack = 1'b1;
        tick(1); irq_ack = 1'b0;
        tick(2);
        @(negedge clk);
        chk("t6_load_ack_busy", int'(irq_busy), 1);
        chk("t6_load_ack_pend", int'(irq_pending[4]), 1);
        ack_after(1);
        @(negedge clk);
        chk("t6_pend_clear", int'(irq_pending[4]), 0);
        irq_src = '0;

        tick(HO + 2);
        chk("sb_drained", exp_q.size(), 0);
        chk("timeout_count", n_to, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
